// File: rtl/vga_board_renderer.sv
// Pixel-colour stage for an 8x8 board display. The block takes the timing
// generator's counters and syncs and produces RGB plus the syncs and
// active_video, all delayed by the same two registers. Board state sits in a
// 64-cell, 2-bit RAM. Game logic writes this RAM through a valid/ready port,
// or a clear sequencer wipes it.
module vga_board_renderer #(
  parameter int H_W   = 10,
  parameter int V_W   = 9,
  parameter int X_OFF = 80,
  parameter int CELL  = 60
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [H_W-1:0] hcount,
  input  logic [V_W-1:0] vcount,
  input  logic           active_in,
  input  logic           hsync_in,
  input  logic           vsync_in,
  input  logic           wr_valid,
  output logic           wr_ready,
  input  logic [5:0]     wr_addr,
  input  logic [1:0]     wr_data,
  input  logic           clr_start,
  output logic           clr_busy,
  output logic [7:0]     red,
  output logic [7:0]     green,
  output logic [7:0]     blue,
  output logic           hsync_out,
  output logic           vsync_out,
  output logic           active_out
);

  localparam int OW = $clog2(CELL);
  localparam logic [H_W-1:0] X_LO    = H_W'(X_OFF);
  localparam logic [H_W-1:0] X_HI    = H_W'(X_OFF + 8 * CELL);
  localparam logic [V_W-1:0] Y_HI    = V_W'(8 * CELL);
  localparam logic [OW-1:0]  IN_LO   = OW'(CELL / 4);
  localparam logic [OW-1:0]  IN_HI   = OW'(CELL - 1 - CELL / 4);
  localparam logic [OW-1:0]  EDGE_HI = OW'(CELL - 2);

  localparam logic [23:0] RGB_BLANK  = 24'h000000;
  localparam logic [23:0] RGB_MARGIN = 24'h202020;
  localparam logic [23:0] RGB_LIGHT  = 24'hF0D9B5;
  localparam logic [23:0] RGB_DARK   = 24'hB58863;
  localparam logic [23:0] RGB_A      = 24'hFFFFFF;
  localparam logic [23:0] RGB_B      = 24'hC00000;
  localparam logic [23:0] RGB_HL     = 24'h00FF00;

  typedef enum logic {IDLE, CLEAR} state_t;

  typedef struct packed {
    logic [2:0]    idx;
    logic [OW-1:0] off;
  } split_t;

  typedef struct packed {
    logic          in_board;
    logic [2:0]    row;
    logic [2:0]    col;
    logic [OW-1:0] ox;
    logic [OW-1:0] oy;
    logic          active;
    logic          hsync;
    logic          vsync;
  } s1_t;

  // Split a board-relative coordinate into a cell index and an in-cell offset.
  // The split uses a compare/subtract ladder and needs no divider. A coordinate
  // beyond the board gives don't-care values, and in_board masks them.
  function automatic split_t split_axis(input logic [H_W-1:0] p);
    split_t r;
    r.idx = '0;
    r.off = OW'(p);
    for (int i = 1; i < 8; i++) begin
      if (p >= H_W'(i * CELL)) begin
        r.idx = 3'(i);
        r.off = OW'(p - H_W'(i * CELL));
      end
    end
    return r;
  endfunction

  s1_t         s1_d, s1_q;
  logic [23:0] rgb_d, rgb_q;
  logic        hsync_d, hsync_q, vsync_d, vsync_q, active_d, active_q;
  state_t      state_d, state_q;
  logic [5:0]  idx_d, idx_q;
  logic        busy_d, busy_q;
  logic [1:0]  cell_d [64];
  logic [1:0]  cell_q [64];

  logic [H_W-1:0] x_rel;
  split_t         sx, sy;
  logic [1:0]     cell_rd;
  logic [23:0]    base_rgb;
  logic           inner, border;

  // Stage 1: board hit test, cell coordinates and in-cell offsets
  always_comb begin
    x_rel          = hcount - X_LO;
    sx             = split_axis(x_rel);
    sy             = split_axis(H_W'(vcount));
    s1_d.in_board  = (hcount >= X_LO) && (hcount < X_HI) && (vcount < Y_HI);
    s1_d.col       = sx.idx;
    s1_d.ox        = sx.off;
    s1_d.row       = sy.idx;
    s1_d.oy        = sy.off;
    s1_d.active    = active_in;
    s1_d.hsync     = hsync_in;
    s1_d.vsync     = vsync_in;
  end

  // Stage 2: read the cell from stage-1 coordinates and pick the pixel colour.
  // The RAM read is combinational from the current cell state, so a write at
  // this same edge shows up only on the next read.
  always_comb begin
    cell_rd  = cell_q[{s1_q.row, s1_q.col}];
    base_rgb = (s1_q.row[0] ^ s1_q.col[0]) ? RGB_DARK : RGB_LIGHT;
    inner    = (s1_q.ox >= IN_LO) && (s1_q.ox <= IN_HI) &&
               (s1_q.oy >= IN_LO) && (s1_q.oy <= IN_HI);
    border   = (s1_q.ox < 2) || (s1_q.ox >= EDGE_HI) ||
               (s1_q.oy < 2) || (s1_q.oy >= EDGE_HI);
    rgb_d    = base_rgb;
    if (!s1_q.active) begin
      rgb_d = RGB_BLANK;
    end else if (!s1_q.in_board) begin
      rgb_d = RGB_MARGIN;
    end else begin
      case (cell_rd)
        2'd1:    if (inner)  rgb_d = RGB_A;
        2'd2:    if (inner)  rgb_d = RGB_B;
        2'd3:    if (border) rgb_d = RGB_HL;
        default: rgb_d = base_rgb;
      endcase
    end
    hsync_d  = s1_q.hsync;
    vsync_d  = s1_q.vsync;
    active_d = s1_q.active;
  end

  // Write port gating. Hold it low in reset, and also on a clear-start cycle
  // so that a write never overlaps a clear.
  assign wr_ready = rst_n && (state_q == IDLE) && !clr_start;
  assign clr_busy = busy_q;

  // Board RAM control: accept writes in IDLE, or zero one cell per cycle in CLEAR
  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    cell_d  = cell_q;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          idx_d   = '0;
          busy_d  = 1'b1;
        end else if (wr_valid && wr_ready) begin
          cell_d[wr_addr] = wr_data;
        end
      end
      CLEAR: begin
        cell_d[idx_q] = 2'd0;
        idx_d         = idx_q + 6'd1;
        if (idx_q == 6'd63) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  // Pipeline registers and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!rst_n) begin
      s1_q     <= '0;
      rgb_q    <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      rgb_q    <= rgb_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
    end
  end

  // FSM state, clear index and board RAM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      // NOTE: the board RAM is flop-based and must read empty after any reset, so it is reset here.
      cell_q  <= '{default: 2'd0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      cell_q  <= cell_d;
    end
  end

  assign red        = rgb_q[23:16];
  assign green      = rgb_q[15:8];
  assign blue       = rgb_q[7:0];
  assign hsync_out  = hsync_q;
  assign vsync_out  = vsync_q;
  assign active_out = active_q;

endmodule
